// File: rtl/nn_pkg.sv
// Shared widths, FSM state encoding and sample record for the sample feeder.
package nn_pkg;

    localparam int unsigned BITS = 16;
    localparam int unsigned NX   = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        NEXT,
        FINISH
    } state_t;

    typedef struct packed {
        logic [NX*BITS-1:0] x;
        logic [BITS-1:0]    y;
    } sample_t;

endpackage

// File: rtl/sample_ram.sv
// Sample storage: one write port, registered synchronous read port.
module sample_ram #(
    parameter int unsigned NS = 64,
    parameter int unsigned W  = $bits(nn_pkg::sample_t),
    parameter int unsigned AW = $clog2(NS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [W-1:0]  rd
);

    logic [W-1:0] mem [NS];

    // Array has no reset so stored samples survive rst_n; only the read register clears.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rd <= '0;
        else if (re) rd <= mem[ra];
    end

endmodule

// File: rtl/sample_feeder.sv
// Streams stored samples to a network for train/validate passes.
// Optional watchdog in WAIT enabled by defining SAMPLE_FEEDER_TIMEOUT_EN.
module sample_feeder #(
    parameter int unsigned NX      = 6,
    parameter int unsigned BITS    = 16,
    parameter int unsigned NS      = 64,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(NS)-1:0]    wr_addr,
    input  logic [NX*BITS-1:0]       wr_x,
    input  logic [BITS-1:0]          wr_y,
    input  logic                     start,
    input  logic                     mode,
    input  logic [7:0]               epochs,
    input  logic [$clog2(NS):0]      n_samples,
    input  logic [BITS-1:0]          lr_cfg,
    input  logic                     net_done,
    input  logic                     yhat,
    output logic [NX*BITS-1:0]       x,
    output logic [BITS-1:0]          y,
    output logic [BITS-1:0]          lr,
    output logic                     TR,
    output logic                     VL,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NS)-1:0]    sample_idx,
    output logic [$clog2(NS):0]      correct_cnt,
    output logic                     err
);

    import nn_pkg::*;

    localparam int unsigned AW = $clog2(NS);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned W  = NX*BITS + BITS;

    state_t         state, state_nx;
    logic           mode_q;
    logic [7:0]     passes_q;
    logic [7:0]     pass_cnt;
    logic [CW-1:0]  n_q;
    logic [CW-1:0]  n_clamp;
    logic           last_idx;
    logic           last_pass;
    logic           wd_hit;
    logic [W-1:0]   rd_data;

    sample_ram #(.NS(NS), .W(W), .AW(AW)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en && (state == IDLE)),
        .wa    (wr_addr),
        .wd    ({wr_x, wr_y}),
        .re    (state == LOAD),
        .ra    (sample_idx),
        .rd    (rd_data)
    );

    // The read register only reloads in LOAD, so x/y hold through WAIT and NEXT.
    assign x    = rd_data[W-1:BITS];
    assign y    = rd_data[BITS-1:0];
    assign busy = (state != IDLE);

    assign n_clamp   = (n_samples > CW'(NS)) ? CW'(NS) : n_samples;
    assign last_idx  = ({1'b0, sample_idx} == (n_q - CW'(1)));
    assign last_pass = (pass_cnt == (passes_q - 8'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        TR       = 1'b0;
        VL       = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    if (start) state_nx = (n_clamp == '0) ? FINISH : LOAD;
            LOAD:    state_nx = ISSUE;
            ISSUE: begin
                TR       = mode_q;
                VL       = !mode_q;
                state_nx = WAIT;
            end
            WAIT: begin
                if (net_done)    state_nx = NEXT;
                else if (wd_hit) state_nx = FINISH;
            end
            NEXT:    state_nx = (last_idx && last_pass) ? FINISH : LOAD;
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= 1'b0;
            passes_q    <= 8'd0;
            pass_cnt    <= 8'd0;
            n_q         <= '0;
            lr          <= '0;
            sample_idx  <= '0;
            correct_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mode_q      <= mode;
                    passes_q    <= (mode && (epochs != 8'd0)) ? epochs : 8'd1;
                    pass_cnt    <= 8'd0;
                    n_q         <= n_clamp;
                    lr          <= lr_cfg;
                    sample_idx  <= '0;
                    correct_cnt <= '0;
                end
                WAIT: if (net_done && !mode_q && (yhat == (y != '0)))
                    correct_cnt <= correct_cnt + CW'(1);
                NEXT: if (last_idx) begin
                    sample_idx <= '0;
                    pass_cnt   <= pass_cnt + 8'd1;
                end else begin
                    sample_idx <= sample_idx + AW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SAMPLE_FEEDER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;

    // wd_cnt counts completed WAIT cycles; it is zero on the first WAIT cycle.
    assign wd_hit = (state == WAIT) && !net_done && (wd_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            wd_cnt <= ((state == WAIT) && !net_done) ? wd_cnt + TW'(1) : '0;
            if ((state == IDLE) && start) err <= 1'b0;
            else if (wd_hit)              err <= 1'b1;
        end
    end
`else
    assign wd_hit = 1'b0;
    assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder with an expected-request queue model.
module tb_sample_feeder;

    localparam int unsigned NX   = 6;
    localparam int unsigned BITS = 16;
    localparam int unsigned NS   = 8;
    localparam int unsigned AW   = 3;
    localparam int unsigned CW   = 4;
    localparam int unsigned TMO  = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                wr_en, start, mode, net_done, yhat;
    logic [AW-1:0]       wr_addr;
    logic [NX*BITS-1:0]  wr_x, x;
    logic [BITS-1:0]     wr_y, lr_cfg, y, lr;
    logic [7:0]          epochs;
    logic [CW-1:0]       n_samples, correct_cnt;
    logic                TR, VL, busy, done, err;
    logic [AW-1:0]       sample_idx;

    sample_feeder #(.NX(NX), .BITS(BITS), .NS(NS), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x),
        .wr_y(wr_y), .start(start), .mode(mode), .epochs(epochs), .n_samples(n_samples),
        .lr_cfg(lr_cfg), .net_done(net_done), .yhat(yhat), .x(x), .y(y), .lr(lr),
        .TR(TR), .VL(VL), .busy(busy), .done(done), .sample_idx(sample_idx),
        .correct_cnt(correct_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   idx;
        logic tr;
    } exp_t;

    int                  tests = 0;
    int                  fails = 0;
    logic [NX*BITS-1:0]  mx [NS];
    logic [BITS-1:0]     my [NS];
    exp_t                exp_q [$];
    int                  seq [$];
    logic [BITS-1:0]     exp_lr;
    int                  req_cnt = 0;
    int                  done_cnt = 0;
    int                  hold = 0;
    logic [NX*BITS+2*BITS-1:0] snap;

    function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endfunction

    // Every request must match the next queued expectation; data must hold until after net_done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold = 0;
        end else begin
            if (TR && VL) check("tr_vl_exclusive", 1, 0);
            if (TR || VL) begin
                req_cnt++;
                seq.push_back(int'(sample_idx));
                if (exp_q.size() == 0) begin
                    check("unexpected_req", {TR, VL}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("req_kind", TR, e.tr);
                    check("req_idx", sample_idx, e.idx);
                    check("req_x", x, mx[e.idx]);
                    check("req_y", y, my[e.idx]);
                    check("req_lr", lr, exp_lr);
                end
                snap = {x, y, lr};
                hold = 1;
            end else if (hold > 0) begin
                check("hold_stable", {x, y, lr}, snap);
                if (hold == 2)     hold = 0;
                else if (net_done) hold = 2;
            end
            if (done) done_cnt++;
        end
    end

    task automatic wr(input int a, input logic [NX*BITS-1:0] vx, input logic [BITS-1:0] vy);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = AW'(a); wr_x = vx; wr_y = vy;
        @(posedge clk); #1;
        wr_en = 1'b0;
        mx[a] = vx;
        my[a] = vy;
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_x"}, x, 0);
        check({nm, "_rest"}, {y, lr, TR, VL, busy, done, sample_idx, correct_cnt, err}, 0);
    endtask

    // One run: queue the expected requests, answer each one, then check the end state.
    task automatic run(input logic md, input logic [7:0] ep, input int n, input logic [BITS-1:0] lrv,
                       input logic [NS-1:0] miss, input int poke_k, input int abort_k);
        int ne, passes, total, w, i, want_cnt;
        logic yh;
        ne       = (n > int'(NS)) ? int'(NS) : n;
        passes   = md ? ((ep == 8'd0) ? 1 : int'(ep)) : 1;
        total    = passes * ne;
        want_cnt = 0;
        exp_lr   = lrv;
        req_cnt  = 0;
        done_cnt = 0;
        seq.delete();
        for (int p = 0; p < passes; p++)
            for (int s = 0; s < ne; s++) exp_q.push_back('{idx: s, tr: md});
        @(posedge clk); #1;
        start = 1'b1; mode = md; epochs = ep; n_samples = CW'(n); lr_cfg = lrv;
        @(posedge clk); #1;
        start = 1'b0; mode = ~md; epochs = 8'hAA; n_samples = CW'(1); lr_cfg = '1;
        for (int k = 0; k < total; k++) begin
            w = 0;
            do begin @(negedge clk); w++; end while (!(TR || VL) && w < 50);
            if (!(TR || VL)) begin
                check("req_timeout", 0, 1);
                break;
            end
            i = k % ne;
            if (k == abort_k) begin
                @(posedge clk); #1;
                rst_n = 1'b0;
                #1;
                check_zero("abort_rst");
                repeat (3) @(posedge clk);
                #1;
                check("abort_no_done", done_cnt, 0);
                exp_q.delete();
                rst_n = 1'b1;
                return;
            end
            yh = (my[i] != '0) ^ miss[i];
            if (!md && !miss[i]) want_cnt++;
            @(posedge clk); #1;
            if (k == poke_k) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = AW'(1); wr_x = '1; wr_y = 16'hDEAD;
                @(posedge clk); #1;
                start = 1'b0; wr_en = 1'b0;
            end
            for (int d = 0; d < k % 3; d++) begin @(posedge clk); #1; end
            net_done = 1'b1; yhat = yh;
            @(posedge clk); #1;
            net_done = 1'b0; yhat = 1'b0;
        end
        w = 0;
        while (done_cnt == 0 && w < 20) begin @(negedge clk); w++; end
        check("done_seen", done_cnt, 1);
        @(negedge clk);
        check("idle_after", busy, 0);
        check("done_once", done_cnt, 1);
        check("req_count", req_cnt, total);
        check("exp_drained", exp_q.size(), 0);
        check("correct_cnt", correct_cnt, want_cnt);
    endtask

    initial begin
        int w;
        int lit [6] = '{0, 1, 2, 0, 1, 2};
        logic [NX*BITS-1:0] vx;
        rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0;
        start = 1'b0; mode = 1'b0; epochs = '0; n_samples = '0; lr_cfg = '0;
        net_done = 1'b0; yhat = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_zero("reset_state");
        @(posedge clk); #1 rst_n = 1'b1;

        for (int a = 0; a < int'(NS); a++) begin
            for (int j = 0; j < int'(NX); j++) vx[j*BITS +: BITS] = BITS'(a*16 + j + 1);
            wr(a, vx, (a % 2 == 0) ? BITS'(0) : BITS'(a*3 + 2));
        end

        // Validate 4 samples, network wrong on index 2 only.
        run(1'b0, 8'd0, 4, 16'h0100, 8'b0000_0100, -1, -1);
        check("v4_vl_pulses", req_cnt, 4);
        check("v4_correct", correct_cnt, 3);
        check("v4_done", done_cnt, 1);
        repeat (5) @(posedge clk);
        #1 check("correct_hold", correct_cnt, 3);

        // Train, 2 epochs over 3 samples.
        run(1'b1, 8'd2, 3, 16'h0020, '0, -1, -1);
        check("t6_tr_pulses", req_cnt, 6);
        check("t6_seq_len", seq.size(), 6);
        for (int k = 0; k < 6 && k < seq.size(); k++) check("t6_seq", seq[k], lit[k]);
        check("t6_correct", correct_cnt, 0);

        // Epochs 0 trains once; start and wr_en poked during WAIT must be ignored.
        run(1'b1, 8'd0, 2, 16'h0033, '0, 1, -1);
        check("ep0_tr_pulses", req_cnt, 2);
        @(posedge clk); #1 net_done = 1'b1;
        @(posedge clk); #1 net_done = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_net_done_busy", busy, 0);
        check("idle_net_done_req", req_cnt, 2);
        check("idle_net_done_done", done_cnt, 1);

        // Reset during WAIT of sample 2, then a full run from preserved memory.
        run(1'b0, 8'd0, 4, 16'h0044, '0, -1, 2);
        run(1'b0, 8'd0, 4, 16'h0055, 8'b0000_1001, -1, -1);
        check("post_rst_correct", correct_cnt, 2);

        // n_samples above depth clamps to NS.
        run(1'b0, 8'd0, 12, 16'h0066, '0, -1, -1);
        check("clamp_vl_pulses", req_cnt, 8);

        // n_samples = 0: done one cycle after start, nothing issued.
        req_cnt = 0; done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1; n_samples = '0; epochs = 8'd3;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("n0_done", done, 1);
        check("n0_busy", busy, 1);
        @(negedge clk);
        check("n0_done_drop", done, 0);
        check("n0_idle", busy, 0);
        check("n0_no_req", req_cnt, 0);

        // Network never answers.
        done_cnt = 0; exp_lr = 16'h0077;
        exp_q.push_back('{idx: 0, tr: 1'b0});
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; n_samples = CW'(1); lr_cfg = 16'h0077;
        @(posedge clk); #1 start = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!VL && w < 20);
        check("tmo_vl_seen", VL, 1);
        w = 0;
        do begin @(negedge clk); w++; end while (!done && w < 40);
`ifdef SAMPLE_FEEDER_TIMEOUT_EN
        check("tmo_cycles", w, 17);
        check("tmo_err", err, 1);
        @(negedge clk);
        check("tmo_err_sticky", err, 1);
        check("tmo_idle", busy, 0);
        run(1'b0, 8'd0, 1, 16'h0088, '0, -1, -1);
        check("tmo_err_cleared", err, 0);
`else
        check("wait_forever_done", done, 0);
        check("wait_forever_busy", busy, 1);
        check("wait_forever_err", err, 0);
        check("wait_forever_done_cnt", done_cnt, 0);
        rst_n = 1'b0;
        #1 check_zero("wait_forever_rst");
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
